// File: rtl/dff_response_checker.sv
// Cycle-accurate reference model and checker for a D flop with async active-low set/clear.
// Snoops the flop's stimulus and Q/Qbar; flags mismatches and illegal set+clear combinations.
module dff_response_checker #(
   parameter int unsigned CNT_W       = 8,
   parameter bit          STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             Rd,
   input  logic             mon_D,
   input  logic             mon_Rd,
   input  logic             mon_Sd,
   input  logic             mon_Q,
   input  logic             mon_Qbar,
   output logic             err,
   output logic             err_sticky,
   output logic             illegal,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_cyc
);

   typedef enum logic [1:0] {StUninit, StTrack, StFail} state_e;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CntOne;
   endfunction

   state_e           state_q, state_d;
   logic             m_q, m_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] first_q, first_d;
   logic             err_q, err_d;
   logic             illegal_q, illegal_d;
   logic             sticky_q, sticky_d;

   logic ctl_illegal, ctl_forced, exp_now, do_check, fail;

   assign ctl_illegal = ~mon_Rd & ~mon_Sd;
   assign ctl_forced  = mon_Rd ^ mon_Sd;
   // Forced values are known even before the model is initialised.
   assign exp_now     = ctl_forced ? mon_Rd : m_q;
   assign do_check    = ((state_q == StTrack) && !ctl_illegal) ||
                        ((state_q == StUninit) && ctl_forced);
   assign fail        = do_check && ((mon_Q != exp_now) || (mon_Qbar == mon_Q));

   always_ff @(posedge clk or negedge Rd) begin
      if (!Rd) begin
         state_q <= StUninit;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StUninit: begin
            if (!ctl_illegal) state_d = (fail && STOP_ON_ERR) ? StFail : StTrack;
         end
         StTrack: begin
            if (fail && STOP_ON_ERR) state_d = StFail;
         end
         StFail:   state_d = StFail;
         default:  state_d = StUninit;
      endcase
   end

   always_comb begin
      m_d = m_q;
      unique case ({mon_Rd, mon_Sd})
         2'b11:   m_d = mon_D;
         2'b01:   m_d = 1'b0;
         2'b10:   m_d = 1'b1;
         default: m_d = m_q;
      endcase
      cyc_d     = sat_inc(cyc_q);
      chk_cnt_d = do_check ? sat_inc(chk_cnt_q) : chk_cnt_q;
      err_cnt_d = fail ? sat_inc(err_cnt_q) : err_cnt_q;
      first_d   = (fail && !sticky_q) ? cyc_q : first_q;
      sticky_d  = sticky_q | fail;
      err_d     = fail;
      illegal_d = ctl_illegal;
   end

   always_ff @(posedge clk or negedge Rd) begin
      if (!Rd) begin
         m_q       <= 1'b0;
         cyc_q     <= '0;
         chk_cnt_q <= '0;
         err_cnt_q <= '0;
         first_q   <= '0;
         sticky_q  <= 1'b0;
         err_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         m_q       <= m_d;
         cyc_q     <= cyc_d;
         chk_cnt_q <= chk_cnt_d;
         err_cnt_q <= err_cnt_d;
         first_q   <= first_d;
         sticky_q  <= sticky_d;
         err_q     <= err_d;
         illegal_q <= illegal_d;
      end
   end

   assign err           = err_q;
   assign err_sticky    = sticky_q;
   assign illegal       = illegal_q;
   assign chk_cnt       = chk_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_cyc = first_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench: three checker instances (default, stop-on-error, 4-bit counters)
// share one stimulus stream; expected values are hand-computed per step.
module tb_dff_response_checker;

   logic clk = 1'b0;
   logic Rd, mon_D, mon_Rd, mon_Sd, mon_Q, mon_Qbar;

   logic       err0, stk0, ill0;
   logic [7:0] chk0, ecnt0, fst0;
   logic       err1, stk1, ill1;
   logic [7:0] chk1, ecnt1, fst1;
   logic       err2, stk2, ill2;
   logic [3:0] chk2, ecnt2, fst2;

   int ntest = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   dff_response_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (
      .clk(clk), .Rd(Rd), .mon_D(mon_D), .mon_Rd(mon_Rd), .mon_Sd(mon_Sd),
      .mon_Q(mon_Q), .mon_Qbar(mon_Qbar), .err(err0), .err_sticky(stk0),
      .illegal(ill0), .chk_cnt(chk0), .err_cnt(ecnt0), .first_err_cyc(fst0)
   );

   dff_response_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (
      .clk(clk), .Rd(Rd), .mon_D(mon_D), .mon_Rd(mon_Rd), .mon_Sd(mon_Sd),
      .mon_Q(mon_Q), .mon_Qbar(mon_Qbar), .err(err1), .err_sticky(stk1),
      .illegal(ill1), .chk_cnt(chk1), .err_cnt(ecnt1), .first_err_cyc(fst1)
   );

   dff_response_checker #(.CNT_W(4), .STOP_ON_ERR(1'b0)) dut2 (
      .clk(clk), .Rd(Rd), .mon_D(mon_D), .mon_Rd(mon_Rd), .mon_Sd(mon_Sd),
      .mon_Q(mon_Q), .mon_Qbar(mon_Qbar), .err(err2), .err_sticky(stk2),
      .illegal(ill2), .chk_cnt(chk2), .err_cnt(ecnt2), .first_err_cyc(fst2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntest++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one edge's worth of monitor inputs, then sample 1 time unit after the edge.
   task automatic step(input logic d, input logic rd, input logic sd,
                       input logic q, input logic qb);
      mon_D    = d;
      mon_Rd   = rd;
      mon_Sd   = sd;
      mon_Q    = q;
      mon_Qbar = qb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      Rd = 1'b0;
      mon_D = 1'b0; mon_Rd = 1'b1; mon_Sd = 1'b1; mon_Q = 1'b0; mon_Qbar = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_err", {31'd0, err0}, 0);
      chk("rst_sticky", {31'd0, stk0}, 0);
      chk("rst_illegal", {31'd0, ill0}, 0);
      chk("rst_chk_cnt", {24'd0, chk0}, 0);
      chk("rst_err_cnt", {24'd0, ecnt0}, 0);
      chk("rst_first", {24'd0, fst0}, 0);

      // Edge 0: forced clear, first check happens straight from UNINIT.
      Rd = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("e0_chk_cnt", {24'd0, chk0}, 1);
      chk("e0_err", {31'd0, err0}, 0);
      chk("e0_err_cnt", {24'd0, ecnt0}, 0);

      // Edges 1..4: correct flop, Q follows D one edge later.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("e1_err", {31'd0, err0}, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("e2_err", {31'd0, err0}, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("e3_chk_cnt", {24'd0, chk0}, 4);
      chk("e3_err_cnt", {24'd0, ecnt0}, 0);
      chk("e3_sticky", {31'd0, stk0}, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("e4_err", {31'd0, err0}, 0);

      // Edge 5: model holds 0, flop shows 1.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("e5_err", {31'd0, err0}, 1);
      chk("e5_err_cnt", {24'd0, ecnt0}, 1);
      chk("e5_sticky", {31'd0, stk0}, 1);
      chk("e5_first", {24'd0, fst0}, 5);
      chk("e5_chk_cnt", {24'd0, chk0}, 6);
      chk("e5_stop_err", {31'd0, err1}, 1);
      chk("e5_stop_first", {24'd0, fst1}, 5);

      // Edge 6: same fault again.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("e6_err", {31'd0, err0}, 1);
      chk("e6_err_cnt", {24'd0, ecnt0}, 2);
      chk("e6_first", {24'd0, fst0}, 5);
      chk("e6_stop_err", {31'd0, err1}, 0);
      chk("e6_stop_err_cnt", {24'd0, ecnt1}, 1);
      chk("e6_stop_chk_cnt", {24'd0, chk1}, 6);
      chk("e6_stop_sticky", {31'd0, stk1}, 1);

      // Edge 7: correct again, err pulse must have ended.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("e7_err", {31'd0, err0}, 0);
      chk("e7_chk_cnt", {24'd0, chk0}, 8);
      chk("e7_sticky", {31'd0, stk0}, 1);

      // Edges 8..10: both controls active.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
         chk($sformatf("ill%0d_illegal", i), {31'd0, ill0}, 1);
         chk($sformatf("ill%0d_chk_cnt", i), {24'd0, chk0}, 8);
         chk($sformatf("ill%0d_err", i), {31'd0, err0}, 0);
         chk($sformatf("ill%0d_stop_illegal", i), {31'd0, ill1}, 1);
      end

      // Edge 11: model must still hold 0 despite D=1 during the illegal edges.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("e11_illegal", {31'd0, ill0}, 0);
      chk("e11_err", {31'd0, err0}, 0);
      chk("e11_chk_cnt", {24'd0, chk0}, 9);

      // Edge 12: Q correct, Qbar wrong.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("e12_qbar_err", {31'd0, err0}, 1);
      chk("e12_err_cnt", {24'd0, ecnt0}, 3);

      // 20 mismatching edges: 4-bit counters saturate.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("sat_err", {31'd0, err0}, 1);
      chk("sat_err_cnt8", {24'd0, ecnt0}, 23);
      chk("sat_chk_cnt8", {24'd0, chk0}, 30);
      chk("sat_first8", {24'd0, fst0}, 5);
      chk("sat_err_cnt4", {28'd0, ecnt2}, 15);
      chk("sat_chk_cnt4", {28'd0, chk2}, 15);
      chk("sat_first4", {28'd0, fst2}, 5);
      chk("sat_stop_err_cnt", {24'd0, ecnt1}, 1);
      chk("sat_stop_chk_cnt", {24'd0, chk1}, 6);

      // Mid-run reset between edges: outputs clear without a clock edge.
      #2;
      Rd = 1'b0;
      #1;
      chk("mid_err", {31'd0, err0}, 0);
      chk("mid_sticky", {31'd0, stk0}, 0);
      chk("mid_chk_cnt", {24'd0, chk0}, 0);
      chk("mid_err_cnt", {24'd0, ecnt0}, 0);
      chk("mid_first", {24'd0, fst0}, 0);
      chk("mid_err_cnt4", {28'd0, ecnt2}, 0);
      chk("mid_stop_sticky", {31'd0, stk1}, 0);
      @(posedge clk);
      #1;
      Rd = 1'b1;

      // Back in UNINIT: illegal edge keeps UNINIT, both-released edge loads without checking.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("un_illegal", {31'd0, ill0}, 1);
      chk("un_chk_cnt0", {24'd0, chk0}, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("un_load_chk_cnt", {24'd0, chk0}, 0);
      chk("un_load_err", {31'd0, err0}, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("un_track_chk_cnt", {24'd0, chk0}, 1);
      chk("un_track_err", {31'd0, err0}, 0);
      chk("un_stop_chk_cnt", {24'd0, chk1}, 1);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
